ncu_ucb_link_mon: RTL and testbench

Parametrised, synthesisable protocol checker for NCU<->MCU-style narrow UCB links. It replaces the per-link, print-only monitoring with one instance per direction covering NUM_CH channels. Each channel tracks packet framing on vld/data, assembles the packet header, counts packets, and raises sticky error flags for protocol violations. It sits beside the NCU in the iol2clk domain; all outputs are observable by testbench scoreboards or a debug CSR block.

---
 rtl/ncu_ucb_link_mon.sv | 129 ++++++++++++
 tb/tb_ncu_ucb_link_mon.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ncu_ucb_link_mon.sv
// Per-channel UCB link protocol monitor: frames vld/data beats into packets, captures headers,
// counts completions and keeps sticky protocol-violation flags.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// BEAT  | inside a packet, beat_cnt beats already received
module ncu_ucb_link_mon #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 4,
  parameter int PKT_BEATS = 32,
  parameter int HDR_BEATS = 16,
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 64
) (
  input  logic                           iol2clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           clr_err,
  input  logic [NUM_CH-1:0]              ch_vld,
  input  logic [NUM_CH*DATA_W-1:0]       ch_data,
  input  logic [NUM_CH-1:0]              ch_stall,
  output logic [NUM_CH-1:0]              pkt_done,
  output logic [NUM_CH*HDR_BEATS*DATA_W-1:0] hdr_out,
  output logic [NUM_CH*CNT_W-1:0]        pkt_cnt,
  output logic [NUM_CH*4-1:0]            err_flags,
  output logic                           err_any
);

  localparam int HDR_W = HDR_BEATS * DATA_W;
  localparam int BW    = $clog2(PKT_BEATS);
  localparam int SW    = $clog2(STALL_MAX + 1);

  typedef enum logic {IDLE = 1'b0, BEAT = 1'b1} state_t;

  logic [NUM_CH*4-1:0] err_nxt_all;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt;
    logic [SW-1:0]     stall_rem;
    logic              stall_q;
    logic [HDR_W-1:0]  shadow, shadow_nxt;
    logic [HDR_W-1:0]  hdr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        err_q, err_nxt;
    logic              done_q;
    logic              start_ev, beat_ev, last_ev, short_ev, stall_to_ev, sat_ev;
    logic              vld, stall;
    logic [DATA_W-1:0] beat;

    assign vld   = ch_vld[i];
    assign stall = ch_stall[i];
    assign beat  = ch_data[i*DATA_W +: DATA_W];

    always_ff @(posedge iol2clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      if (!enable) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:    if (vld) state_nxt = BEAT;
          BEAT:    if (!vld || int'(beat_cnt) == PKT_BEATS - 1) state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end

    always_comb begin
      start_ev    = enable && (state == IDLE) && vld;
      beat_ev     = enable && (state == BEAT) && vld;
      last_ev     = beat_ev && (int'(beat_cnt) == PKT_BEATS - 1);
      short_ev    = enable && (state == BEAT) && !vld;
      stall_to_ev = enable && stall && (stall_rem == SW'(1));
      sat_ev      = last_ev && (&cnt_q);
      shadow_nxt  = shadow;
      for (int s = 0; s < HDR_BEATS; s++) begin
        if ((start_ev && s == 0) || (beat_ev && int'(beat_cnt) == s))
          shadow_nxt[s*DATA_W +: DATA_W] = beat;
      end
      // a set event in the same cycle as clr_err must survive the clear
      err_nxt = (clr_err ? 4'b0000 : err_q) |
                {sat_ev, start_ev && stall_q, stall_to_ev, short_ev};
    end

    always_ff @(posedge iol2clk) begin
      if (rst) begin
        beat_cnt  <= '0;
        stall_rem <= SW'(STALL_MAX);
        stall_q   <= 1'b0;
        shadow    <= '0;
        hdr_q     <= '0;
        cnt_q     <= '0;
        err_q     <= '0;
        done_q    <= 1'b0;
      end else begin
        stall_q <= stall;
        shadow  <= shadow_nxt;
        done_q  <= last_ev;
        err_q   <= err_nxt;
        if (start_ev)     beat_cnt <= BW'(1);
        else if (beat_ev) beat_cnt <= beat_cnt + BW'(1);
        if (last_ev) begin
          hdr_q <= shadow_nxt;
          if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        end
        // stall-run timer counts down from STALL_MAX; terminal count parks at zero
        if (!enable || !stall)     stall_rem <= SW'(STALL_MAX);
        else if (stall_rem != '0)  stall_rem <= stall_rem - SW'(1);
      end
    end

    assign pkt_done[i]                  = done_q;
    assign hdr_out[i*HDR_W +: HDR_W]    = hdr_q;
    assign pkt_cnt[i*CNT_W +: CNT_W]    = cnt_q;
    assign err_flags[i*4 +: 4]          = err_q;
    assign err_nxt_all[i*4 +: 4]        = err_nxt;
  end

  always_ff @(posedge iol2clk) begin
    if (rst) err_any <= 1'b0;
    else     err_any <= |err_nxt_all;
  end

endmodule

// File: tb/tb_ncu_ucb_link_mon.sv
// Bench for ncu_ucb_link_mon: table of single-channel scenarios plus hand-written
// sequences; completed packets are checked through an expected-packet queue.
module tb_ncu_ucb_link_mon;

  logic          iol2clk = 1'b0;
  logic          rst = 1'b1, enable = 1'b1, clr_err = 1'b0;
  logic [3:0]    ch_vld = '0, ch_stall = '0;
  logic [15:0]   ch_data = '0;

  logic [3:0]    pkt_done;
  logic [255:0]  hdr_out;
  logic [63:0]   pkt_cnt;
  logic [15:0]   err_flags;
  logic          err_any;

  logic [3:0]    s_pkt_done;
  logic [255:0]  s_hdr_out;
  logic [7:0]    s_pkt_cnt;
  logic [15:0]   s_err_flags;
  logic          s_err_any;

  ncu_ucb_link_mon dut (
    .iol2clk(iol2clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .ch_vld(ch_vld), .ch_data(ch_data), .ch_stall(ch_stall),
    .pkt_done(pkt_done), .hdr_out(hdr_out), .pkt_cnt(pkt_cnt),
    .err_flags(err_flags), .err_any(err_any)
  );

  ncu_ucb_link_mon #(.CNT_W(2)) dut_sat (
    .iol2clk(iol2clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .ch_vld(ch_vld), .ch_data(ch_data), .ch_stall(ch_stall),
    .pkt_done(s_pkt_done), .hdr_out(s_hdr_out), .pkt_cnt(s_pkt_cnt),
    .err_flags(s_err_flags), .err_any(s_err_any)
  );

  always #5 iol2clk = ~iol2clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_cnt_v[4];
  int s_done_n = 0;
  bit sat_phase = 1'b0;

  typedef struct {
    int          ch;
    logic [63:0] hdr;
    int          cnt;
    int          due;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int         ch;
    int         pre_stall;
    int         nbeats;
    bit         follow_full;
    int         seed;
    logic [3:0] exp_err;
    int         exp_cnt;
  } vec_t;
  vec_t vecs[8];

  always @(posedge iol2clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every done pulse must match the oldest expected packet
  always @(negedge iol2clk) begin
    for (int c = 0; c < 4; c++) begin
      if (pkt_done[c]) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: ch%0d pulsed at cycle %0d, none expected", c, cyc);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("done_ch", 64'(c), 64'(e.ch));
          check("done_cycle", 64'(cyc), 64'(e.due));
          check("done_hdr", hdr_out[c*64 +: 64], e.hdr);
          check("done_cnt", 64'(pkt_cnt[c*16 +: 16]), 64'(e.cnt));
        end
      end
    end
    if (s_pkt_done[0]) begin
      s_done_n++;
      if (sat_phase && s_done_n == 3) check("sat_err3_before", 64'(s_err_flags[3]), 64'd0);
      if (sat_phase && s_done_n == 4) check("sat_err3_on_4th", 64'(s_err_flags[3]), 64'd1);
    end
  end

  task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic [3:0] s);
    @(negedge iol2clk);
    ch_vld   = v;
    ch_data  = d;
    ch_stall = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0, 16'h0, 4'b0);
  endtask

  task automatic do_reset();
    @(negedge iol2clk);
    rst = 1'b1; ch_vld = '0; ch_stall = '0; ch_data = '0; clr_err = 1'b0; enable = 1'b1;
    repeat (2) @(negedge iol2clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) exp_cnt_v[c] = 0;
  endtask

  task automatic send_frame(input int ch, input int nbeats, input int seed);
    logic [63:0] h;
    logic [3:0]  d;
    sb_t         e;
    h = '0;
    for (int b = 0; b < nbeats; b++) begin
      d = 4'((b + seed) % 16);
      if (b < 16) h[b*4 +: 4] = d;
      drive(4'(1 << ch), 16'(d) << (ch * 4), 4'b0);
      if (b == 31) begin
        exp_cnt_v[ch]++;
        e.ch = ch; e.hdr = h; e.cnt = exp_cnt_v[ch]; e.due = cyc + 1;
        sbq.push_back(e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0,  0, 32, 0, 0, 4'b0000, 1};
    vecs[1] = '{1,  0, 11, 1, 3, 4'b0001, 1};
    vecs[2] = '{2, 64,  0, 0, 0, 4'b0010, 0};
    vecs[3] = '{2, 63,  0, 0, 0, 4'b0000, 0};
    vecs[4] = '{3,  1, 32, 0, 5, 4'b0100, 1};
    vecs[5] = '{1, 63, 32, 0, 9, 4'b0100, 1};
    vecs[6] = '{2,  0, 31, 0, 7, 4'b0001, 0};
    vecs[7] = '{3,  0,  1, 0, 2, 4'b0001, 0};

    do_reset();
    @(negedge iol2clk);
    check("rst_done", 64'(pkt_done), 64'd0);
    check("rst_hdr", 64'(|hdr_out), 64'd0);
    check("rst_cnt", pkt_cnt, 64'd0);
    check("rst_err", 64'(err_flags), 64'd0);
    check("rst_err_any", 64'(err_any), 64'd0);

    foreach (vecs[k]) begin
      do_reset();
      for (int s = 0; s < vecs[k].pre_stall; s++) drive(4'b0, 16'h0, 4'(1 << vecs[k].ch));
      if (vecs[k].nbeats > 0) send_frame(vecs[k].ch, vecs[k].nbeats, vecs[k].seed);
      if (vecs[k].follow_full) begin
        idle(1);
        send_frame(vecs[k].ch, 32, vecs[k].seed + 1);
      end
      idle(3);
      check($sformatf("vec%0d_err", k), 64'(err_flags), 64'(16'(vecs[k].exp_err) << (vecs[k].ch * 4)));
      check($sformatf("vec%0d_err_any", k), 64'(err_any), 64'(vecs[k].exp_err != 4'b0));
      check($sformatf("vec%0d_cnt", k), pkt_cnt, 64'(vecs[k].exp_cnt) << (vecs[k].ch * 16));
      if (k == 0) check("vec0_hdr_const", hdr_out[63:0], 64'hFEDCBA9876543210);
    end

    // stall timeout edge, clr_err, and set-wins-over-clear on ch2
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive(4'b0, 16'h0, 4'b0100);
      if (i == 63) check("stall_63_edges", 64'(err_flags[9]), 64'd0);
    end
    drive(4'b0, 16'h0, 4'b0);
    check("stall_64_edges", 64'(err_flags[9]), 64'd1);
    check("stall_err_any", 64'(err_any), 64'd1);
    drive(4'b0, 16'h0, 4'b0);
    clr_err = 1'b1;
    drive(4'b0, 16'h0, 4'b0);
    clr_err = 1'b0;
    check("clr_err_flags", 64'(err_flags), 64'd0);
    check("clr_err_any", 64'(err_any), 64'd0);
    for (int i = 0; i < 64; i++) begin
      drive(4'b0, 16'h0, 4'b0100);
      if (i == 63) clr_err = 1'b1;
    end
    drive(4'b0, 16'h0, 4'b0);
    clr_err = 1'b0;
    check("set_wins_clr", 64'(err_flags), 64'h0200);

    // reset in the middle of a packet
    do_reset();
    send_frame(0, 20, 0);
    do_reset();
    @(negedge iol2clk);
    check("midrst_done", 64'(pkt_done), 64'd0);
    check("midrst_cnt", pkt_cnt, 64'd0);
    check("midrst_err", 64'(err_flags), 64'd0);
    check("midrst_hdr", 64'(|hdr_out), 64'd0);
    send_frame(0, 32, 6);
    idle(3);
    check("midrst_new_cnt", pkt_cnt, 64'd1);
    check("midrst_new_err", 64'(err_flags), 64'd0);

    // enable dropped in the middle of a packet
    do_reset();
    send_frame(0, 32, 4);
    send_frame(0, 20, 8);
    drive(4'b0001, 16'h5, 4'b0);
    enable = 1'b0;
    drive(4'b0001, 16'h6, 4'b0);
    drive(4'b0001, 16'h7, 4'b0);
    drive(4'b0, 16'h0, 4'b0);
    check("en_off_cnt_held", pkt_cnt, 64'd1);
    check("en_off_no_err", 64'(err_flags), 64'd0);
    enable = 1'b1;
    idle(1);
    send_frame(0, 32, 11);
    idle(3);
    check("en_new_cnt", pkt_cnt, 64'd2);
    check("en_new_err", 64'(err_flags), 64'd0);
    check("en_new_err_any", 64'(err_any), 64'd0);

    // saturation with a 2-bit counter: five back-to-back packets on ch0
    do_reset();
    sat_phase = 1'b1;
    s_done_n = 0;
    for (int p = 0; p < 5; p++) send_frame(0, 32, p);
    idle(3);
    sat_phase = 1'b0;
    check("sat_cnt", 64'(s_pkt_cnt), 64'd3);
    check("sat_err", 64'(s_err_flags), 64'h0008);
    check("sat_err_any", 64'(s_err_any), 64'd1);
    check("sat_done_pulses", 64'(s_done_n), 64'd5);
    check("wide_cnt", pkt_cnt, 64'd5);

    idle(5);
    check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
